calc_operand_sequencer: RTL

Byte-serial front end for the 8-bit three-operand calculator stage. It accepts a 4-byte command frame (op, a, b, c) over a valid/ready byte stream and holds the operands stable on the calculator's input ports. After one cycle it captures the calculator's combinational result and carry, then returns them over a valid/ready response channel. It sits directly upstream of the calculator and also registers that stage's output.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_operand_sequencer_if.sv | 23 ++
 rtl/calc_seq_timer.sv | 29 ++
 rtl/calc_operand_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator operand sequencer.
package calc_pkg;

    localparam int CALC_W           = 8;
    localparam int CALC_OP_W        = 2;
    localparam int CALC_FRAME_BYTES = 4;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_C    = 3'd3,
        S_EXEC = 3'd4,
        S_RESP = 3'd5
    } calc_seq_state_t;

    function automatic logic is_operand_state(calc_seq_state_t s);
        return (s == S_A) || (s == S_B) || (s == S_C);
    endfunction

endpackage

// File: rtl/calc_operand_sequencer_if.sv
// Byte-stream request and result response channels of the operand sequencer.
interface calc_operand_sequencer_if;
    import calc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [CALC_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CALC_W-1:0] out_r;
    logic              out_carry;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_r, out_carry
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_r, out_carry
    );

endinterface

// File: rtl/calc_seq_timer.sv
// Inter-byte timeout: down-counter reloaded on clear, expires at terminal count.
module calc_seq_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int              CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= LOAD;
        end else if (i_clear) begin
            r_count <= LOAD;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Expires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
    assign o_expire = i_enable && !i_clear && (r_count == '0);

endmodule

// File: rtl/calc_operand_sequencer.sv
// Collects op/a/b/c bytes, drives the calculator, returns its registered result.
// Optional inter-byte timeout enabled by defining CALC_SEQ_TIMEOUT_EN.
//
// state  | meaning
// S_OP   | waiting for op byte
// S_A    | waiting for operand a
// S_B    | waiting for operand b
// S_C    | waiting for operand c
// S_EXEC | operands stable, calculator settling
// S_RESP | result held until consumer accepts
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_operand_sequencer_if.slave bus,
    output logic [CALC_W-1:0]    calc_a,
    output logic [CALC_W-1:0]    calc_b,
    output logic [CALC_W-1:0]    calc_c,
    output logic [CALC_OP_W-1:0] calc_op,
    input  logic [CALC_W-1:0]    calc_r,
    input  logic                 calc_cout,
    output logic [7:0]           frames_done,
    output logic                 err_timeout
);
    calc_seq_state_t      r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [CALC_W-1:0]    r_out_r;
    logic                 r_out_carry;
    logic [CALC_W-1:0]    r_calc_a;
    logic [CALC_W-1:0]    r_calc_b;
    logic [CALC_W-1:0]    r_calc_c;
    logic [CALC_OP_W-1:0] r_calc_op;
    logic [7:0]           r_frames_done;
    logic                 r_err_timeout;

    logic w_in_xfer;
    logic w_expire;

    assign w_in_xfer = bus.in_valid && r_in_ready;

`ifdef CALC_SEQ_TIMEOUT_EN
    logic w_tmr_clear;
    logic w_tmr_enable;

    assign w_tmr_clear  = w_in_xfer || (r_state == S_OP);
    assign w_tmr_enable = is_operand_state(r_state) && !w_in_xfer;

    calc_seq_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_enable),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES < 1);
    assign w_expire             = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_OP;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_r       <= '0;
            r_out_carry   <= 1'b0;
            r_calc_a      <= '0;
            r_calc_b      <= '0;
            r_calc_c      <= '0;
            r_calc_op     <= '0;
            r_frames_done <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= 1'b0;
            case (r_state)
                S_OP: begin
                    if (w_in_xfer) begin
                        r_calc_op <= bus.in_data[CALC_OP_W-1:0];
                        r_state   <= S_A;
                    end
                end
                S_A, S_B, S_C: begin
                    if (w_in_xfer) begin
                        case (r_state)
                            S_A:     begin r_calc_a <= bus.in_data; r_state <= S_B; end
                            S_B:     begin r_calc_b <= bus.in_data; r_state <= S_C; end
                            default: begin
                                r_calc_c   <= bus.in_data;
                                r_state    <= S_EXEC;
                                r_in_ready <= 1'b0;
                            end
                        endcase
                    end else if (w_expire) begin
                        // Partial operands are left in place; only the frame is dropped.
                        r_state       <= S_OP;
                        r_err_timeout <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_out_r     <= calc_r;
                    r_out_carry <= calc_cout;
                    r_out_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.out_ready) begin
                        r_out_valid   <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_frames_done <= r_frames_done + 8'd1;
                        r_state       <= S_OP;
                    end
                end
                default: begin
                    r_state     <= S_OP;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_r     = r_out_r;
    assign bus.out_carry = r_out_carry;
    assign calc_a        = r_calc_a;
    assign calc_b        = r_calc_b;
    assign calc_c        = r_calc_c;
    assign calc_op       = r_calc_op;
    assign frames_done   = r_frames_done;
    assign err_timeout   = r_err_timeout;

endmodule
